// File: rtl/aes_round_core_if.sv
// Bus between the AES round core and its neighbours: round-key write port,
// start controls, and the result/handshake outputs.
interface aes_round_core_if #(
  parameter int unsigned KEY_ADDR_W = 4,
  parameter int unsigned BLK_W      = 128
);
  logic                  key_w_en;
  logic [KEY_ADDR_W-1:0] key_w_addr;
  logic [BLK_W-1:0]      key_w_data;
  logic [3:0]            rounds_total;
  logic                  en_cipher;
  logic                  en_decipher;
  logic [BLK_W-1:0]      in_blk;
  logic [BLK_W-1:0]      out_blk;
  logic                  en_o;
  logic                  busy;

  modport master (
    output key_w_en, key_w_addr, key_w_data, rounds_total, en_cipher, en_decipher, in_blk,
    input  out_blk, en_o, busy
  );

  modport slave (
    input  key_w_en, key_w_addr, key_w_data, rounds_total, en_cipher, en_decipher, in_blk,
    output out_blk, en_o, busy
  );
endinterface

// File: rtl/aes_round_core.sv
// Iterative AES-128/256 encrypt/decrypt engine: one key addition every 3 cycles
// (fetch, memory wait, apply) against an internal 16-entry round-key memory.
module aes_round_core #(
  parameter int unsigned KEY_ADDR_W = 4,
  parameter int unsigned BLK_W      = 128
) (
  input logic            clk,
  input logic            reset,
  aes_round_core_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StApply, StDone} state_e;

  // GF(2^8) arithmetic over x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) begin
      o[8*i +: 8] = inv ? inv_sbox(s[8*i +: 8]) : sbox(s[8*i +: 8]);
    end
    return o;
  endfunction

  // Byte i sits at [127-8i -: 8]; row = i % 4, column = i / 4
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int           src;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*src) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] mix_coef(input logic inv, input int unsigned idx);
    case (idx)
      0:       return inv ? 8'h0e : 8'h02;
      1:       return inv ? 8'h0b : 8'h03;
      2:       return inv ? 8'h0d : 8'h01;
      default: return inv ? 8'h09 : 8'h01;
    endcase
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127-8*(4*c+k) -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) begin
          acc = acc ^ gf_mul(mix_coef(inv, unsigned'((k - r + 4) % 4)), a[k]);
        end
        o[127-8*(4*c+r) -: 8] = acc;
      end
    end
    return o;
  endfunction

  state_e                r_state, w_state_nxt;
  logic [BLK_W-1:0]      r_key_mem [2**KEY_ADDR_W];
  logic [BLK_W-1:0]      r_mem_rd, r_key;
  logic [BLK_W-1:0]      r_blk, r_out_blk;
  logic [3:0]            r_nr, r_step;
  logic                  r_decrypt;

  logic                  w_busy, w_start, w_first, w_last;
  logic [KEY_ADDR_W-1:0] w_rd_addr;
  logic [BLK_W-1:0]      w_enc_sr, w_enc_mid, w_enc_last, w_dec_ark, w_round_out;

  assign w_busy    = (r_state != StIdle);
  assign w_start   = !w_busy && (bus.en_cipher || bus.en_decipher);
  assign w_first   = (r_step == 4'd0);
  assign w_last    = (r_step == r_nr);
  // Decryption walks the schedule from key Nr down to key 0
  assign w_rd_addr = r_decrypt ? KEY_ADDR_W'(r_nr - r_step) : KEY_ADDR_W'(r_step);

  always_ff @(posedge clk) begin
    if (bus.key_w_en && !w_busy) r_key_mem[bus.key_w_addr] <= bus.key_w_data;
    r_mem_rd <= r_key_mem[w_rd_addr];
    r_key    <= r_mem_rd;
  end

  assign w_enc_sr   = shift_rows(sub_bytes(r_blk, 1'b0), 1'b0);
  assign w_enc_mid  = mix_columns(w_enc_sr, 1'b0) ^ r_key;
  assign w_enc_last = w_enc_sr ^ r_key;
  assign w_dec_ark  = sub_bytes(shift_rows(r_blk, 1'b1), 1'b1) ^ r_key;

  always_comb begin
    w_round_out = r_blk ^ r_key;
    if (!w_first) begin
      if (r_decrypt) w_round_out = w_last ? w_dec_ark : mix_columns(w_dec_ark, 1'b1);
      else           w_round_out = w_last ? w_enc_last : w_enc_mid;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_start) w_state_nxt = StFetch;
      StFetch: w_state_nxt = StWait;
      StWait:  w_state_nxt = StApply;
      StApply: w_state_nxt = w_last ? StDone : StFetch;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_blk     <= '0;
      r_out_blk <= '0;
      r_nr      <= 4'd10;
      r_step    <= '0;
      r_decrypt <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_blk     <= bus.in_blk;
        r_decrypt <= !bus.en_cipher;
        r_nr      <= (bus.rounds_total == 4'd10) ? 4'd10 : 4'd14;
        r_step    <= '0;
      end else if (r_state == StApply) begin
        r_blk  <= w_round_out;
        r_step <= r_step + 4'd1;
        if (w_last) r_out_blk <= w_round_out;
      end
    end
  end

  assign bus.out_blk = r_out_blk;
  assign bus.en_o    = (r_state == StDone);
  assign bus.busy    = w_busy;

endmodule

// File: tb/tb_aes_round_core.sv
// Bench for aes_round_core: FIPS-197 vectors, busy/reset corner cases and
// random blocks/keys checked against a byte-level AES model.
module tb_aes_round_core;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_round_core_if bus ();
  aes_round_core u_dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]   m_sbox     [256];
  logic [7:0]   m_inv_sbox [256];
  logic [127:0] m_rk       [15];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Carry-less product, then reduction by 0x11B
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++) begin
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      end
      m_sbox[x]     = s;
      m_inv_sbox[s] = 8'(x);
    end
  endtask

  function automatic logic [7:0] get_b(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] m_sub(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv ? m_inv_sbox[get_b(s, i)] : m_sbox[get_b(s, i)];
    return o;
  endfunction

  // Row r rotates left by r (forward) or right by r (inverse)
  function automatic logic [127:0] m_shift(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = get_b(s, r + 4 * (inv ? (c + 4 - r) % 4 : (c + r) % 4));
    return o;
  endfunction

  function automatic logic [127:0] m_mix(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    logic [7:0]   cf [4];
    logic [7:0]   acc;
    if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(cf[(k - r + 4) % 4], get_b(s, 4 * c + k));
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] aes_model(input logic [127:0] blk, input bit dec, input int nr);
    logic [127:0] s;
    if (!dec) begin
      s = blk ^ m_rk[0];
      for (int r = 1; r < nr; r++) s = m_mix(m_shift(m_sub(s, 0), 0), 0) ^ m_rk[r];
      s = m_shift(m_sub(s, 0), 0) ^ m_rk[nr];
    end else begin
      s = blk ^ m_rk[nr];
      for (int r = nr - 1; r >= 1; r--) s = m_mix(m_sub(m_shift(s, 1), 1) ^ m_rk[r], 1);
      s = m_sub(m_shift(s, 1), 1) ^ m_rk[0];
    end
    return s;
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {t[23:0], t[31:24]};
        t = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]};
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic load_keys(input int n);
    for (int i = 0; i < n; i++) begin
      bus.key_w_en   = 1'b1;
      bus.key_w_addr = 4'(i);
      bus.key_w_data = m_rk[i];
      @(posedge clk); #1;
    end
    bus.key_w_en = 1'b0;
  endtask

  // Called in an idle cycle; returns in the idle cycle following en_o
  task automatic run_op(input string tag, input logic [127:0] blk, input bit enc, input bit dec,
                        input logic [3:0] nrf, input int inject_at, input logic [127:0] exp);
    int lat;
    int exp_lat;
    exp_lat = 3 * (((nrf == 4'd10) ? 10 : 14) + 1);
    bus.in_blk       = blk;
    bus.rounds_total = nrf;
    bus.en_cipher    = enc;
    bus.en_decipher  = dec;
    @(posedge clk); #1;
    bus.en_cipher   = 1'b0;
    bus.en_decipher = 1'b0;
    check_eq({tag, "_busy"}, 128'(bus.busy), 128'(1));
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (bus.en_o) break;
      if (lat == inject_at) begin
        bus.en_decipher = 1'b1;
        bus.key_w_en    = 1'b1;
        bus.key_w_addr  = 4'd3;
        bus.key_w_data  = '0;
      end else if (lat == inject_at + 1) begin
        bus.en_decipher = 1'b0;
        bus.key_w_en    = 1'b0;
      end
    end
    check_eq({tag, "_en_o"}, 128'(bus.en_o), 128'(1));
    check_eq({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    check_eq({tag, "_out"}, bus.out_blk, exp);
    @(posedge clk); #1;
    check_eq({tag, "_idle"}, 128'({bus.busy, bus.en_o}), 128'(0));
    check_eq({tag, "_hold"}, bus.out_blk, exp);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int            cnt;
    int            mode;
    logic [3:0]    nrf;
    logic [127:0]  blk;
    reset            = 1'b0;
    bus.key_w_en     = 1'b0;
    bus.key_w_addr   = '0;
    bus.key_w_data   = '0;
    bus.rounds_total = 4'd10;
    bus.en_cipher    = 1'b0;
    bus.en_decipher  = 1'b0;
    bus.in_blk       = '0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_blk", bus.out_blk, 128'(0));
    check_eq("rst_busy", 128'(bus.busy), 128'(0));
    check_eq("rst_en_o", 128'(bus.en_o), 128'(0));
    reset = 1'b1;
    @(posedge clk); #1;

    expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    load_keys(11);
    run_op("c1_enc", PT, 1'b1, 1'b0, 4'd10, -1, CT128);
    run_op("c1_dec", CT128, 1'b0, 1'b1, 4'd10, -1, PT);

    expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    load_keys(15);
    run_op("c3_enc", PT, 1'b1, 1'b0, 4'd14, -1, CT256);
    run_op("c3_dec", CT256, 1'b0, 1'b1, 4'd14, -1, PT);
    run_op("busy_ign", PT, 1'b1, 1'b0, 4'd14, 5, CT256);
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.en_o) cnt++;
    end
    check_eq("busy_extra_en_o", 128'(cnt), 128'(0));
    run_op("both_start", PT, 1'b1, 1'b1, 4'd14, -1, CT256);

    for (int it = 0; it < 24; it++) begin
      for (int k = 0; k < 15; k++) m_rk[k] = {$urandom, $urandom, $urandom, $urandom};
      load_keys(15);
      blk  = {$urandom, $urandom, $urandom, $urandom};
      mode = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0:       nrf = 4'd10;
        1:       nrf = 4'd14;
        default: nrf = 4'($urandom_range(0, 15));
      endcase
      run_op("rand", blk, mode != 1, mode != 0, nrf, -1,
             aes_model(blk, mode == 1, (nrf == 4'd10) ? 10 : 14));
    end

    expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    load_keys(11);
    bus.in_blk       = PT;
    bus.rounds_total = 4'd10;
    bus.en_cipher    = 1'b1;
    @(posedge clk); #1;
    bus.en_cipher = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_eq("midrst_out_blk", bus.out_blk, 128'(0));
    check_eq("midrst_busy", 128'(bus.busy), 128'(0));
    check_eq("midrst_en_o", 128'(bus.en_o), 128'(0));
    cnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.en_o) cnt++;
    end
    reset = 1'b1;
    repeat (45) begin
      @(posedge clk); #1;
      if (bus.en_o) cnt++;
    end
    check_eq("midrst_no_en_o", 128'(cnt), 128'(0));
    run_op("rst_restart", PT, 1'b1, 1'b0, 4'd10, -1, CT128);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
